// File: rtl/hex_ascii_pkg.sv
// hex_ascii_pkg: shared states, ASCII constants and nibble encoder for the hex streamer
package hex_ascii_pkg;
  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} hex_state_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_X = 8'h78;
  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_LF = 8'h0a;
  localparam logic [7:0] ASCII_UC_OFS = 8'h37;
  localparam logic [7:0] ASCII_LC_OFS = 8'h57;
  function automatic logic [7:0] nib2ascii(input logic [3:0] nibble, input logic lowercase);
    return (nibble < 4'd10) ? ASCII_0 + {4'h0, nibble}
                            : (lowercase ? ASCII_LC_OFS : ASCII_UC_OFS) + {4'h0, nibble};
  endfunction
endpackage

// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer: serializes an N-nibble word as hex ASCII text, one char per handshake
module hex_ascii_streamer
  import hex_ascii_pkg::*;
#(
  parameter int NNIBBLES = 4,
  parameter int PREFIX = 1,
  parameter int LOWERCASE = 0,
  parameter int SUPPRESS_ZEROS = 0,
  parameter int TERM = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*NNIBBLES-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_char,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);
  localparam int IW = (NNIBBLES > 1) ? $clog2(NNIBBLES) : 1;
  hex_state_t state, state_nx;
  logic [IW-1:0] idx, idx_nx, lead, idx_dec;
  logic [4*NNIBBLES-1:0] word, word_nx;
  logic [7:0] char_nx;
  logic valid_nx, hs;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign hs = out_valid && out_ready;
  assign idx_dec = idx - IW'(1);
  // leading-zero priority encoder: highest nonzero nibble wins, zero word yields 0
  always_comb begin
    lead = (SUPPRESS_ZEROS != 0) ? '0 : IW'(NNIBBLES - 1);
    if (SUPPRESS_ZEROS != 0)
      for (int i = 0; i < NNIBBLES; i++)
        if (in_data[4*i +: 4] != 4'h0) lead = IW'(i);
  end
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    word_nx = word;
    char_nx = out_char;
    valid_nx = out_valid;
    case (state)
      IDLE: if (in_valid) begin
        word_nx = in_data;
        idx_nx = lead;
        state_nx = (PREFIX != 0) ? PFX0 : DIGIT;
        char_nx = (PREFIX != 0) ? ASCII_0 : nib2ascii(in_data[{lead, 2'b00} +: 4], LOWERCASE != 0);
        valid_nx = 1'b1;
      end
      PFX0: if (hs) begin
        state_nx = PFX1;
        char_nx = ASCII_X;
      end
      PFX1: if (hs) begin
        state_nx = DIGIT;
        char_nx = nib2ascii(word[{idx, 2'b00} +: 4], LOWERCASE != 0);
      end
      DIGIT: if (hs) begin
        if (idx != '0) begin
          idx_nx = idx_dec;
          char_nx = nib2ascii(word[{idx_dec, 2'b00} +: 4], LOWERCASE != 0);
        end else begin
          state_nx = (TERM != 0) ? CR : IDLE;
          char_nx = (TERM != 0) ? ASCII_CR : out_char;
          valid_nx = TERM != 0;
        end
      end
      CR: if (hs) begin
        state_nx = LF;
        char_nx = ASCII_LF;
      end
      LF: if (hs) begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      word <= '0;
      out_char <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      word <= word_nx;
      out_char <= char_nx;
      out_valid <= valid_nx;
    end
  end
endmodule

// File: doc/hex_ascii_streamer.md
# hex_ascii_streamer

Sequential, parametrised hex-to-ASCII serializer for the keyboard/display path. Accepts an N-nibble binary word over a valid/ready handshake and emits its hexadecimal text one ASCII character per handshake. Options: `0x` prefix, lowercase digits, leading-zero suppression and a CR/LF terminator. Sits between scan-code/debug producers and the UART TX or character-display writer.

## Interface
- `NNIBBLES`, default 4: number of hex digits in the input word (1..16).
- `PREFIX`, default 1: 1 emits `0x` before the digits.
- `LOWERCASE`, default 0: 1 emits `a`–`f`; 0 emits `A`–`F`. Prefix `x` is always lowercase.
- `SUPPRESS_ZEROS`, default 0: 1 skips leading zero nibbles; at least one digit is always emitted.
- `TERM`, default 0: 1 appends CR (0x0D) then LF (0x0A).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 4*NNIBBLES: binary word. Nibble NNIBBLES-1 is the most significant and is sent first.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word. Equals state==IDLE (combinational from state).
- `out_char` out 8: ASCII character (registered).
- `out_valid` out 1: `out_char` is valid (registered).
- `out_ready` in 1: downstream accepts `out_char`.
- `busy` out 1: state != IDLE.

## Operation
- States:
  - IDLE
  - PFX0 (`0`, 0x30)
  - PFX1 (`x`, 0x78)
  - DIGIT
  - CR
  - LF
- Accept: when `in_valid && in_ready`:
  - Latch `in_data` into the word register.
  - Load digit index `idx`:
    - SUPPRESS_ZEROS=1: index of the most significant nonzero nibble, or 0 if the word is zero.
    - SUPPRESS_ZEROS=0: NNIBBLES-1.
  - Go to PFX0 if PREFIX, else to DIGIT.
- Each state drives its character into `out_char` with `out_valid`=1 on entry.
- The state advances only on an output handshake (`out_valid && out_ready`):
  - PFX0 → PFX1 → DIGIT.
  - DIGIT with `idx`>0: decrement `idx`, stay in DIGIT with the next character.
  - DIGIT with `idx`==0: go to CR if TERM, else IDLE.
  - CR → LF → IDLE.
- Digit encoding:
  - Nibble 0–9 → 0x30+n.
  - Nibble 10–15 → 0x37+n (uppercase) or 0x57+n (lowercase).
  - Computed in 8-bit unsigned arithmetic, no overflow.
- Backpressure: while `out_valid && !out_ready`, `out_char`, `out_valid`, state and `idx` hold unchanged.
- `in_valid` is ignored outside IDLE. The latched word is immune to later `in_data` changes.
- Reset mid-stream: an asynchronous drop of `rst_n` aborts the stream immediately. The partial word is discarded and never resumed.

## Timing
- Reset values:
  - state=IDLE, so `in_ready`=1 and `busy`=0.
  - `out_valid`=0, `out_char`=0x00, `idx`=0, word register=0.
- Latency: the first character is valid in the cycle after the accept edge.
- Throughput: one character per cycle with `out_ready` held high.
- Stream length is P+D+T characters:
  - P = 2·PREFIX.
  - D = NNIBBLES, or the number of significant digits when suppressing.
  - T = 2·TERM.
- After the last character's handshake:
  - `out_valid`=0 and `in_ready`=1 in the next cycle.
  - One bubble cycle between words; no accept in the same cycle as the final handshake.
- `out_valid` never drops without a handshake, except on reset.
- `out_char` is don't-care-stable: it holds its last value while `out_valid`=0.

## Structure
- Package `hex_ascii_pkg`:
  - State enum `hex_state_t`.
  - Constants `ASCII_0`, `ASCII_X`, `ASCII_CR`, `ASCII_LF`, `ASCII_UC_OFS` (0x37), `ASCII_LC_OFS` (0x57).
  - Function `nib2ascii(nibble, lowercase)`.
- No sub-module. The leading-zero priority encoder is a function or always_comb block inside the module.
- Default parameters must stay drop-in for 16-bit keyboard scan display.

## Test plan
- Defaults (NNIBBLES=4, PREFIX=1), `in_data`=0x1A2F, `out_ready`=1:
  - Chars 0x30,0x78,0x31,0x41,0x32,0x46 on six consecutive cycles.
  - Then `out_valid`=0 and `in_ready`=1.
- Same word, `out_ready` toggling 1-0-1-0:
  - Identical sequence; `out_char` stable during every stall.
  - No duplicated or dropped characters.
- SUPPRESS_ZEROS=1, PREFIX=0:
  - 0x00B0 → `B0` (0x42,0x30).
  - 0x0000 → `0` (0x30) only.
  - 0xF000 → `F000`.
- LOWERCASE=1, TERM=1, PREFIX=0, `in_data`=0xBEEF → 0x62,0x65,0x65,0x66,0x0D,0x0A.
- Assert `rst_n`=0 after the third character of 0x1A2F:
  - All outputs return to reset values immediately.
  - Next word 0x0001 streams completely: `0x0001`.
- `in_valid` pulsed with 0xFFFF while busy:
  - Ignored; the current word completes unchanged.
  - New word accepted only when `in_ready`=1.
